// File: rtl/fp_unit_sequencer.sv
// Issues buffered float operands one at a time to a multi-cycle unit and returns results on a
// valid/ready stream; no issue unless the output register is free, so results never back up into the unit.
module fp_unit_sequencer #(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          UNIT_LATENCY = 17,
  parameter int          TIMEOUT      = 32,
  parameter logic [31:0] NAN_VALUE    = 32'h7FC00000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_timeout,
  output logic        unit_clk_en,
  output logic [31:0] unit_dataa,
  input  logic [31:0] unit_result,
  input  logic        unit_done,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(UNIT_LATENCY + 2);
  localparam logic [CW-1:0] DEPTH      = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FLUSH_LEN  = FW'(UNIT_LATENCY + 1);

  typedef enum logic [1:0] {FLUSH, IDLE, BUSY} state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [FW-1:0] flush_cnt;
  logic          push;
  logic          pop;

  assign in_ready = reset_n && (count != DEPTH);
  assign push     = in_valid && in_ready;
  // Issue only when the result register is guaranteed free by the time the unit finishes.
  assign pop      = (state == IDLE) && (count != '0) && (!out_valid || out_ready);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= FLUSH;
      flush_cnt   <= FLUSH_LEN;
      timer       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      unit_clk_en <= 1'b0;
      unit_dataa  <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        FLUSH: begin
          // The unit has no reset; wait out any operation it may still be finishing.
          unit_clk_en <= 1'b0;
          if (flush_cnt <= FW'(1)) begin
            flush_cnt <= '0;
            state     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        IDLE: begin
          if (pop) begin
            unit_dataa  <= mem[rd_ptr];
            unit_clk_en <= 1'b1;
            timer       <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (unit_done) begin
            out_data    <= unit_result;
            out_valid   <= 1'b1;
            out_timeout <= 1'b0;
            unit_clk_en <= 1'b0;
            state       <= IDLE;
          end else if (timer == TIMER_LAST) begin
            out_data    <= NAN_VALUE;
            out_valid   <= 1'b1;
            out_timeout <= 1'b1;
            unit_clk_en <= 1'b0;
            flush_cnt   <= FLUSH_LEN;
            state       <= FLUSH;
          end else if (timer != '1) begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          unit_clk_en <= 1'b0;
          flush_cnt   <= FLUSH_LEN;
          state       <= FLUSH;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_unit_sequencer.sv
// Directed and randomized bench for fp_unit_sequencer with a behavioural multi-cycle unit model.
module tb_fp_unit_sequencer;
  localparam int          UL  = 17;
  localparam int          TO  = 32;
  localparam logic [31:0] NAN = 32'h7FC00000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_timeout;
  logic        unit_clk_en;
  logic [31:0] unit_dataa;
  logic [31:0] unit_result;
  logic        unit_done;
  logic        busy;

  logic model_en = 1'b1;
  logic stray = 1'b0;
  int   ucyc = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  fp_unit_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_timeout(out_timeout),
    .unit_clk_en(unit_clk_en), .unit_dataa(unit_dataa), .unit_result(unit_result),
    .unit_done(unit_done), .busy(busy)
  );

  always #5 clock = ~clock;

  // Unit model: result mapping; 1.0 maps to e as the real exp unit would.
  function automatic logic [31:0] unit_fn(input logic [31:0] a);
    if (a == 32'h3F800000) return 32'h402DF854;
    return {a[7:0], a[31:8]} ^ 32'h5A5A0F0F;
  endfunction

  // The unit counts enabled cycles and pulses done in the UL-th one.
  always @(posedge clock) ucyc <= unit_clk_en ? ucyc + 1 : 0;
  assign unit_done   = stray || (model_en && unit_clk_en && ucyc == UL - 1);
  assign unit_result = stray ? 32'hDEADBEEF : unit_fn(unit_dataa);

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(output bit ok, output int hi);
    ok = 1'b0;
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      if (unit_clk_en) hi++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    bit          seen;
    int          hi;
    int          n;
    int          fb;
    int          t_prev;
    int          sent;
    int          recv;
    logic [31:0] ops [5];
    logic [31:0] p1, p2, x, y, z, w, exp_d;
    logic [31:0] q [$];

    // Reset state, then the post-reset flush length.
    reset_n = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_timeout", out_timeout, 0);
    check("rst_clk_en", unit_clk_en, 0);
    check("rst_dataa", unit_dataa, 0);
    check("rst_busy", busy, 1);
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    check("flush_len", n, UL + 1);
    check("idle_in_ready", in_ready, 1);

    // Single operand 1.0.
    in_valid = 1'b1; in_data = 32'h3F800000;
    tick();
    in_valid = 1'b0;
    check("t1_not_issued_yet", unit_clk_en, 0);
    wait_out(ok, hi);
    check("t1_wait", ok, 1);
    check("t1_clk_en_cycles", hi, UL);
    check("t1_data", out_data, 32'h402DF854);
    check("t1_timeout", out_timeout, 0);
    check("t1_dataa_held", unit_dataa, 32'h3F800000);
    tick();
    check("t1_accepted", out_valid, 0);

    // One op in flight, four queued back-to-back fill the FIFO.
    for (int i = 0; i < 5; i++) ops[i] = $urandom;
    in_valid = 1'b1; in_data = ops[0];
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("t2_first_busy", unit_clk_en, 1);
    for (int i = 1; i < 5; i++) begin
      in_valid = 1'b1; in_data = ops[i];
      if (i == 4) check("t2_ready_before_last", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    check("t2_full", in_ready, 0);
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_out(ok, hi);
      check("t2_wait", ok, 1);
      check("t2_data", out_data, unit_fn(ops[i]));
      if (i > 0) check("t2_gap", cyc - t_prev, UL + 1);
      t_prev = cyc;
    end
    tick();

    // Output backpressure holds the result and blocks the next issue.
    out_ready = 1'b0;
    p1 = $urandom; p2 = $urandom;
    in_valid = 1'b1; in_data = p1; tick();
    in_data = p2; tick();
    in_valid = 1'b0;
    wait_out(ok, hi);
    check("t3_wait", ok, 1);
    check("t3_data1", out_data, unit_fn(p1));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_hold_flags", {out_valid, unit_clk_en}, 2'b10);
      check("t3_hold_data", out_data, unit_fn(p1));
    end
    out_ready = 1'b1;
    tick();
    check("t3_issue_on_ready", unit_clk_en, 1);
    check("t3_valid_cleared", out_valid, 0);
    check("t3_dataa2", unit_dataa, p2);
    wait_out(ok, hi);
    check("t3_data2", out_data, unit_fn(p2));
    tick();

    // Unit never answers: timeout, then a flush before the next issue.
    model_en = 1'b0;
    x = $urandom;
    in_valid = 1'b1; in_data = x; tick();
    in_valid = 1'b0;
    wait_out(ok, hi);
    check("t4_wait", ok, 1);
    check("t4_busy_cycles", hi, TO);
    check("t4_nan", out_data, NAN);
    check("t4_timeout_flag", out_timeout, 1);
    model_en = 1'b1;
    y = $urandom;
    in_valid = 1'b1; in_data = y;
    n = 0;
    fb = busy ? 1 : 0;
    while (!unit_clk_en && n < 60) begin
      tick(); n++;
      in_valid = 1'b0;
      if (busy && !unit_clk_en) fb++;
    end
    check("t4_flush_cycles", fb, UL + 1);
    check("t4_issue_gap", n, UL + 2);
    wait_out(ok, hi);
    check("t4_data_after", out_data, unit_fn(y));
    check("t4_timeout_clear", out_timeout, 0);
    tick();

    // Reset during BUSY cycle 5, stray done during the flush.
    model_en = 1'b0;
    z = $urandom;
    in_valid = 1'b1; in_data = z; tick();
    in_valid = 1'b0;
    n = 0;
    while (!unit_clk_en && n < 10) begin tick(); n++; end
    check("t5_issued", unit_clk_en, 1);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check("t5_rst_in_ready", in_ready, 0);
    tick();
    check("t5_rst_flags", {out_valid, unit_clk_en, busy}, 3'b001);
    check("t5_rst_dataa", unit_dataa, 0);
    reset_n = 1'b1;
    model_en = 1'b1;
    w = $urandom;
    in_valid = 1'b1; in_data = w;
    n = 0;
    seen = 1'b0;
    while (!unit_clk_en && n < 60) begin
      stray = (n == 11);
      tick(); n++;
      in_valid = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    stray = 1'b0;
    check("t5_issue_after_reset", n, UL + 2);
    check("t5_no_out_valid", seen, 0);
    check("t5_dataa", unit_dataa, w);
    wait_out(ok, hi);
    check("t5_data", out_data, unit_fn(w));
    tick();

    // Stray done while idle with nothing queued.
    stray = 1'b1; tick(); stray = 1'b0;
    check("t6_flags", {out_valid, busy, unit_clk_en}, 3'b000);
    tick();
    check("t6_still_idle", out_valid, 0);

    // Random traffic against an in-order scoreboard.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 3000 && recv < 30; c++) begin
      in_valid  = (sent < 30) && ($urandom_range(0, 1) == 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      if (out_valid && out_ready) begin
        if (q.size() > 0) exp_d = q.pop_front();
        else exp_d = 32'hFFFFFFFF;
        check("rand_data", out_data, exp_d);
        check("rand_timeout", out_timeout, 0);
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(unit_fn(in_data));
        sent++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_all_received", recv, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
